// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous square wave in clk_in cycles, flags in-range
// periods and a stalled input. Optional high-phase width capture: PERIOD_METER_HIGH_TIME_EN.
module period_meter #(
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned EXPECTED   = 20000002,
  parameter int unsigned TOL        = 4,
  parameter int unsigned MAX_PERIOD = 40000004
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             in_range,
  output logic             timeout,
  output logic [CNT_W-1:0] high_time_out
);

  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_PERIOD);
  // One extra bit keeps EXPECTED-TOL and EXPECTED+TOL representable without wrap.
  localparam logic [CNT_W:0]   RangeLo = (EXPECTED > TOL) ? (CNT_W+1)'(EXPECTED - TOL) : '0;
  localparam logic [CNT_W:0]   RangeHi = (CNT_W+1)'(EXPECTED + TOL);

  typedef enum logic [1:0] {StIdle, StMeasure, StTimeout} state_e;

  state_e           r_state, w_state_d;
  logic             r_s1, r_s2, r_s3;
  logic             w_rise;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_period, w_period_d;
  logic             r_valid, w_valid_d;
  logic             r_in_range, w_in_range_d;
  logic             r_timeout, w_timeout_d;
  logic [CNT_W:0]   w_cnt_ext;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_cnt_ext = {1'b0, r_cnt};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_in_range <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_period   <= w_period_d;
      r_valid    <= w_valid_d;
      r_in_range <= w_in_range_d;
      r_timeout  <= w_timeout_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_period_d   = r_period;
    w_valid_d    = 1'b0;
    w_in_range_d = r_in_range;
    w_timeout_d  = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_d = StMeasure;
          w_cnt_d   = CNT_W'(1);
        end
      end
      StMeasure: begin
        // A rise on the MAX_PERIOD cycle still reports a period rather than timing out.
        if (w_rise) begin
          w_period_d   = r_cnt;
          w_valid_d    = 1'b1;
          w_in_range_d = (w_cnt_ext >= RangeLo) && (w_cnt_ext <= RangeHi);
          w_cnt_d      = CNT_W'(1);
        end else if (r_cnt == MaxCnt) begin
          w_state_d   = StTimeout;
          w_timeout_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StTimeout: begin
        if (w_rise) begin
          w_state_d   = StMeasure;
          w_cnt_d     = CNT_W'(1);
          w_timeout_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign in_range     = r_in_range;
  assign timeout      = r_timeout;

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic             w_fall;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high;

  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_high <= '0;
    end else begin
      if (w_rise) begin
        r_hcnt <= CNT_W'(1);
      end else if ((r_state == StMeasure) && (r_hcnt != MaxCnt)) begin
        r_hcnt <= r_hcnt + CNT_W'(1);
      end
      if ((r_state == StMeasure) && w_fall) begin
        r_high <= r_hcnt;
      end
    end
  end

  assign high_time_out = r_high;
`else
  assign high_time_out = '0;
`endif

endmodule
